// File: rtl/keypad_entry_if.sv
// Signal bundle between the keypad scanner and its neighbours: the keypad matrix on one
// side, and the seven-segment driver / operand consumer on the other.
interface keypad_entry_if;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [0:15] o_data;
    logic [3:0]  o_key;
    logic        o_key_valid;
    logic        o_refresh_display;
    logic [2:0]  o_nibble_count;
    logic [1:0]  dbg_state;

    // Handshake: no ready exists; o_key_valid and o_refresh_display are single-cycle strobes
    // that rise in the first cycle o_data/o_key/o_nibble_count hold the new entry, and a
    // consumer must sample on that cycle because nothing is held back for it.
    modport master (
        output col,
        output o_data,
        output o_key,
        output o_key_valid,
        output o_refresh_display,
        output o_nibble_count,
        output dbg_state,
        input  row
    );

    modport slave (
        input  col,
        input  o_data,
        input  o_key,
        input  o_key_valid,
        input  o_refresh_display,
        input  o_nibble_count,
        input  dbg_state,
        output row
    );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner with whole-scan debouncing; each accepted key is shifted into
// a 16-bit word as its newest nibble.
module keypad_entry #(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic           clk,
    input  logic           clr,
    keypad_entry_if.master kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);
    localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESS_DB = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_REL_DB   = 2'd3
    } state_e;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    logic [3:0]       row_s1_q, row_s2_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;
    logic [1:0]       acc_hits_q, acc_hits_d;
    logic [3:0]       acc_code_q, acc_code_d;
    state_e           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [0:15]      data_q, data_d;
    logic [3:0]       key_q, key_d;
    logic [2:0]       nib_q, nib_d;
    logic             pulse_q, pulse_d;

    logic [2:0]       col_hits;
    logic [3:0]       col_code;
    logic [2:0]       hits_sum;
    logic [1:0]       scan_hits;
    logic [3:0]       scan_code;
    logic             col_end, scan_end, scan_none, scan_key;
    logic [DB_W-1:0]  db_inc;
    logic             accept;

    // Rows seen low in the column currently driven.
    always_comb begin
        col_hits = 3'd0;
        col_code = 4'h0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s2_q[r]) begin
                col_hits = col_hits + 3'd1;
                col_code = key_code(2'(r), col_idx_q);
            end
        end
    end

    // Hit count saturates at 2 so NONE / KEY / MULTI is all that survives across columns.
    always_comb begin
        col_end   = (div_q == DIV_LAST);
        scan_end  = col_end && (col_idx_q == 2'd3);
        hits_sum  = {1'b0, acc_hits_q} + col_hits;
        scan_hits = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
        scan_code = (col_hits != 3'd0) ? col_code : acc_code_q;
        scan_none = (scan_hits == 2'd0);
        scan_key  = (scan_hits == 2'd1);
        db_inc    = db_cnt_q + DB_ONE;

        div_d      = col_end ? '0 : div_q + 1'b1;
        col_idx_d  = col_end ? col_idx_q + 2'd1 : col_idx_q;
        col_d      = col_end ? {col_q[2:0], col_q[3]} : col_q;
        acc_hits_d = acc_hits_q;
        acc_code_d = acc_code_q;
        if (scan_end) begin
            acc_hits_d = 2'd0;
            acc_code_d = 4'h0;
        end else if (col_end) begin
            acc_hits_d = scan_hits;
            acc_code_d = scan_code;
        end
    end

    // Next-state logic: one transition per completed scan.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        db_cnt_d = db_cnt_q;
        accept   = 1'b0;
        if (scan_end) begin
            unique case (state_q)
                ST_RELEASED: begin
                    if (scan_key) begin
                        cand_d   = scan_code;
                        db_cnt_d = DB_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept  = 1'b1;
                            state_d = ST_PRESSED;
                        end else begin
                            state_d = ST_PRESS_DB;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (scan_key && (scan_code == cand_q)) begin
                        db_cnt_d = db_inc;
                        if (db_inc == DB_TARGET) begin
                            accept  = 1'b1;
                            state_d = ST_PRESSED;
                        end
                    end else if (scan_key) begin
                        cand_d   = scan_code;
                        db_cnt_d = DB_ONE;
                    end else begin
                        state_d = ST_RELEASED;
                    end
                end
                ST_PRESSED: begin
                    if (scan_none) begin
                        db_cnt_d = DB_ONE;
                        state_d  = (DEBOUNCE_SCANS == 1) ? ST_RELEASED : ST_REL_DB;
                    end
                end
                ST_REL_DB: begin
                    if (scan_none) begin
                        db_cnt_d = db_inc;
                        if (db_inc == DB_TARGET) state_d = ST_RELEASED;
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_RELEASED;
            endcase
        end
    end

    // Output logic: shift in the accepted nibble and raise the strobe in the same edge.
    always_comb begin
        data_d  = data_q;
        key_d   = key_q;
        nib_d   = nib_q;
        pulse_d = accept;
        if (accept) begin
            data_d = {data_q[4:15], scan_code};
            key_d  = scan_code;
            nib_d  = (nib_q == 3'd4) ? 3'd4 : nib_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            row_s1_q   <= 4'hF;
            row_s2_q   <= 4'hF;
            div_q      <= '0;
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            acc_hits_q <= 2'd0;
            acc_code_q <= 4'h0;
            state_q    <= ST_RELEASED;
            cand_q     <= 4'h0;
            db_cnt_q   <= '0;
            data_q     <= '0;
            key_q      <= 4'h0;
            nib_q      <= 3'd0;
            pulse_q    <= 1'b0;
        end else begin
            row_s1_q   <= kp.row;
            row_s2_q   <= row_s1_q;
            div_q      <= div_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            acc_hits_q <= acc_hits_d;
            acc_code_q <= acc_code_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            db_cnt_q   <= db_cnt_d;
            data_q     <= data_d;
            key_q      <= key_d;
            nib_q      <= nib_d;
            pulse_q    <= pulse_d;
        end
    end

    assign kp.col               = col_q;
    assign kp.o_data            = data_q;
    assign kp.o_key             = key_q;
    assign kp.o_key_valid       = pulse_q;
    assign kp.o_refresh_display = pulse_q;
    assign kp.o_nibble_count    = nib_q;
    assign kp.dbg_state         = state_q;
endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a physical keypad model drives the rows from the pressed-key set,
// and a per-scan debounce model predicts every accepted key.
module tb_keypad_entry;
    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] pressed_mask = 16'h0;
    logic [3:0]  row_drive;

    keypad_entry_if kp();

    keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(DB)) dut (
        .clk (clk),
        .clr (clr),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_drive = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed_mask[r*4+c] && !kp.col[c]) row_drive[r] = 1'b0;
    end
    assign kp.row = row_drive;

    int key_tab[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

    int n_checks = 0;
    int n_errors = 0;
    int pulse_cnt = 0;
    logic prev_valid = 1'b0;

    // {count[2:0], data[15:0], key[3:0]}
    logic [22:0] exp_q[$];

    int          run_key;
    int          run_len;
    bit          held;
    logic [15:0] m_data;
    logic [2:0]  m_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] key_mask(input int code);
        logic [15:0] m;
        m = 16'h0;
        for (int i = 0; i < 16; i++) if (key_tab[i] == code) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        run_key = -1;
        run_len = 0;
        held    = 1'b0;
        m_data  = 16'h0;
        m_count = 3'd0;
    endtask

    // One full scan with the given key set held throughout.
    task automatic model_scan(input logic [15:0] mask);
        int n;
        int k;
        n = $countones(mask);
        k = -1;
        for (int i = 0; i < 16; i++) if (mask[i]) k = key_tab[i];
        if (!held) begin
            if (n == 1) begin
                if (k == run_key) run_len++;
                else begin
                    run_key = k;
                    run_len = 1;
                end
                if (run_len >= DB) begin
                    held    = 1'b1;
                    run_len = 0;
                    m_data  = {m_data[11:0], 4'(k)};
                    m_count = (m_count == 3'd4) ? 3'd4 : m_count + 3'd1;
                    exp_q.push_back({m_count, m_data, 4'(k)});
                end
            end else begin
                run_key = -1;
                run_len = 0;
            end
        end else begin
            if (n == 0) begin
                run_len++;
                if (run_len >= DB) begin
                    held    = 1'b0;
                    run_len = 0;
                    run_key = -1;
                end
            end else begin
                run_len = 0;
            end
        end
    endtask

    task automatic wait_scan_start();
        int guard;
        logic [3:0] prev;
        guard = 0;
        prev = kp.col;
        @(negedge clk);
        while (!(kp.col == 4'b1110 && prev == 4'b0111) && guard < 200) begin
            prev = kp.col;
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("scan_start_timeout", guard, 0);
    endtask

    task automatic hold_scans(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            pressed_mask = mask;
            model_scan(mask);
            wait_scan_start();
        end
    endtask

    task automatic tap_key(input int code);
        hold_scans(key_mask(code), 3);
        hold_scans(16'h0, 3);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_col"}, kp.col, 4'b1110);
        check({tag, "_data"}, kp.o_data, 0);
        check({tag, "_key"}, kp.o_key, 0);
        check({tag, "_count"}, kp.o_nibble_count, 0);
        check({tag, "_valid"}, kp.o_key_valid, 0);
        check({tag, "_refresh"}, kp.o_refresh_display, 0);
    endtask

    // Pulse monitor: every strobe must be predicted, single-cycle, and carry the model's entry.
    always @(negedge clk) begin
        logic [22:0] e;
        if (!clr && (kp.o_key_valid || kp.o_refresh_display)) begin
            check("refresh_with_valid", kp.o_refresh_display, kp.o_key_valid);
            check("pulse_width", prev_valid, 0);
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("pulse_key", kp.o_key, e[3:0]);
                check("pulse_data", kp.o_data, e[19:4]);
                check("pulse_count", kp.o_nibble_count, e[22:20]);
            end
        end
        prev_valid = kp.o_key_valid;
    end

    initial begin
        int p0;
        logic [3:0] exp_col;
        logic [15:0] m;
        int sel;
        model_reset();

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        clr = 1'b0;
        for (int k = 0; k < 17; k++) begin
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check("col_seq", kp.col, exp_col);
            @(negedge clk);
        end
        wait_scan_start();

        // single press of key 5
        p0 = pulse_cnt;
        tap_key(5);
        check("single_pulses", pulse_cnt - p0, 1);
        check("single_key", kp.o_key, 5);
        check("single_data", kp.o_data, 16'h0005);
        check("single_count", kp.o_nibble_count, 1);

        // bounce: key present one scan, absent one scan
        p0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            hold_scans(key_mask(5), 1);
            hold_scans(16'h0, 1);
        end
        hold_scans(16'h0, 2);
        check("bounce_pulses", pulse_cnt - p0, 0);
        check("bounce_data", kp.o_data, 16'h0005);

        // asynchronous reset in the middle of a debounce and a scan
        hold_scans(key_mask(9), 1);
        #3;
        clr = 1'b1;
        pressed_mask = 16'h0;
        model_reset();
        #1;
        check_all_zero("async_clr");
        @(negedge clk);
        clr = 1'b0;
        wait_scan_start();

        // entry and shift
        p0 = pulse_cnt;
        tap_key(10);
        check("entry_1", kp.o_data, 16'h000A);
        tap_key(1);
        check("entry_2", kp.o_data, 16'h00A1);
        tap_key(11);
        check("entry_3", kp.o_data, 16'h0A1B);
        tap_key(2);
        check("entry_4", kp.o_data, 16'hA1B2);
        tap_key(15);
        check("entry_5", kp.o_data, 16'h1B2F);
        check("entry_count_sat", kp.o_nibble_count, 4);
        check("entry_pulses", pulse_cnt - p0, 5);

        // two keys together, then a long hold
        p0 = pulse_cnt;
        hold_scans(key_mask(1) | key_mask(2), 4);
        check("multi_pulses", pulse_cnt - p0, 0);
        hold_scans(key_mask(3), 10);
        hold_scans(16'h0, 3);
        check("hold_pulses", pulse_cnt - p0, 1);
        check("hold_key", kp.o_key, 3);
        check("hold_data", kp.o_data, 16'hB2F3);

        // reset one scan into a debounce of key 7
        p0 = pulse_cnt;
        hold_scans(key_mask(7), 1);
        #2;
        clr = 1'b1;
        pressed_mask = 16'h0;
        model_reset();
        @(negedge clk);
        clr = 1'b0;
        wait_scan_start();
        check("clr_db_pulses", pulse_cnt - p0, 0);
        tap_key(7);
        check("clr_db_data", kp.o_data, 16'h0007);
        check("clr_db_count", kp.o_nibble_count, 1);

        // random key activity
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 3);
            m = 16'h0;
            if (sel >= 1) m[$urandom_range(0, 15)] = 1'b1;
            if (sel == 3) m[$urandom_range(0, 15)] = 1'b1;
            hold_scans(m, $urandom_range(1, 4));
        end
        hold_scans(16'h0, 3);
        check("rand_data", kp.o_data, m_data);
        check("rand_count", kp.o_nibble_count, m_count);
        check("pending_expected", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
